// File: rtl/simd_alu_pipe.sv
// SIMD integer ALU: per-lane operations evaluated at issue, then PIPE_DEPTH register stages with backpressure.
// Define SIMD_ALU_MUL_EN to include the per-lane multiplier (opcode 2); otherwise opcode 2 is illegal.
module simd_alu_pipe #(
  parameter int NUM_LANES  = 8,
  parameter int DATA_W     = 32,
  parameter int PIPE_DEPTH = 2,
  parameter int WARP_W     = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_op,
  input  logic [WARP_W-1:0]             in_warp_id,
  input  logic [NUM_LANES-1:0]          in_mask,
  input  logic [NUM_LANES*DATA_W-1:0]   in_src1,
  input  logic [NUM_LANES*DATA_W-1:0]   in_src2,
  input  logic [15:0]                   in_imm,
  input  logic                          in_imm_valid,
  input  logic                          in_reg_write,
  input  logic [4:0]                    in_dst,
  input  logic                          in_beq,
  input  logic                          in_blt,
  input  logic [1:0]                    in_scb_id,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WARP_W-1:0]             out_warp_id,
  output logic [NUM_LANES-1:0]          out_mask,
  output logic [4:0]                    out_dst,
  output logic [1:0]                    out_scb_id,
  output logic                          out_reg_write,
  output logic [NUM_LANES*DATA_W-1:0]   out_data,
  output logic                          out_is_branch,
  output logic [NUM_LANES-1:0]          out_br_taken,
  output logic [31:0]                   out_br_target,
  output logic                          err_illegal_op
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int HALF = DATA_W / 2;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_AND = 4'd3,
    OP_OR  = 4'd4, OP_XOR = 4'd5, OP_SRA = 4'd6, OP_SLL = 4'd7,
    OP_SLT = 4'd8, OP_MIN = 4'd9, OP_MAX = 4'd10
  } op_e;

  typedef struct packed {
    logic                        valid;
    logic [WARP_W-1:0]           warp_id;
    logic [NUM_LANES-1:0]        mask;
    logic [4:0]                  dst;
    logic [1:0]                  scb_id;
    logic                        reg_write;
    logic [NUM_LANES*DATA_W-1:0] data;
    logic                        is_branch;
    logic [NUM_LANES-1:0]        br_taken;
    logic [31:0]                 br_target;
  } stage_t;

  stage_t                      pipe [PIPE_DEPTH];
  stage_t                      nxt;
  logic                        advance;
  logic                        illegal;
  logic                        use_imm;
  logic                        is_branch;
  logic [DATA_W-1:0]           imm_ext;
  logic [NUM_LANES*DATA_W-1:0] lane_data;
  logic [NUM_LANES-1:0]        lane_taken;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign is_branch = in_beq || in_blt;
  assign imm_ext   = DATA_W'($signed(in_imm));

  always_comb begin
    illegal = 1'b0;
    use_imm = 1'b0;
    case (op_e'(in_op))
      OP_ADD, OP_AND, OP_OR, OP_XOR, OP_SLT: use_imm = in_imm_valid;
`ifdef SIMD_ALU_MUL_EN
      OP_SUB, OP_MUL, OP_SRA, OP_SLL, OP_MIN, OP_MAX: use_imm = 1'b0;
`else
      OP_SUB, OP_SRA, OP_SLL, OP_MIN, OP_MAX: use_imm = 1'b0;
`endif
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] bo;
    logic [DATA_W-1:0] res;
    lane_data  = '0;
    lane_taken = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      a   = in_src1[i*DATA_W +: DATA_W];
      b   = in_src2[i*DATA_W +: DATA_W];
      bo  = use_imm ? imm_ext : b;
      res = '0;
      case (op_e'(in_op))
        OP_ADD: res = a + bo;
        OP_SUB: res = a - bo;
`ifdef SIMD_ALU_MUL_EN
        OP_MUL: res = DATA_W'(a[HALF-1:0]) * DATA_W'(bo[HALF-1:0]);
`endif
        OP_AND: res = a & bo;
        OP_OR:  res = a | bo;
        OP_XOR: res = a ^ bo;
        OP_SRA: res = $signed(a) >>> bo[SH_W-1:0];
        OP_SLL: res = a << bo[SH_W-1:0];
        OP_SLT: res = ($signed(a) < $signed(bo)) ? DATA_W'(1) : '0;
        OP_MIN: res = ($signed(a) < $signed(bo)) ? a : bo;
        OP_MAX: res = ($signed(a) < $signed(bo)) ? bo : a;
        default: res = '0;
      endcase
      lane_data[i*DATA_W +: DATA_W] = in_mask[i] ? res : '0;
      // Branch compares always use the raw src2; BEQ wins when both types are flagged.
      lane_taken[i] = in_mask[i] && (in_beq ? (a == b) : ($signed(a) < $signed(b)));
    end
  end

  always_comb begin
    nxt = '0;
    if (in_valid) begin
      nxt.valid     = 1'b1;
      nxt.warp_id   = in_warp_id;
      nxt.mask      = in_mask;
      nxt.dst       = in_dst;
      nxt.scb_id    = in_scb_id;
      nxt.br_target = {14'b0, in_imm, 2'b00};
      if (is_branch) begin
        nxt.is_branch = 1'b1;
        nxt.br_taken  = lane_taken;
      end else if (!illegal) begin
        nxt.reg_write = in_reg_write;
        nxt.data      = lane_data;
      end
    end
  end

  // Whole pipe shifts in lockstep on advance, so bubbles travel with the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
    end else if (advance) begin
      pipe[0] <= nxt;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_illegal_op <= 1'b0;
    else if (in_valid && advance && illegal && !is_branch)
      err_illegal_op <= 1'b1;
  end

  assign out_valid     = pipe[PIPE_DEPTH-1].valid;
  assign out_warp_id   = pipe[PIPE_DEPTH-1].warp_id;
  assign out_mask      = pipe[PIPE_DEPTH-1].mask;
  assign out_dst       = pipe[PIPE_DEPTH-1].dst;
  assign out_scb_id    = pipe[PIPE_DEPTH-1].scb_id;
  assign out_reg_write = pipe[PIPE_DEPTH-1].reg_write;
  assign out_data      = pipe[PIPE_DEPTH-1].data;
  assign out_is_branch = pipe[PIPE_DEPTH-1].is_branch;
  assign out_br_taken  = pipe[PIPE_DEPTH-1].br_taken;
  assign out_br_target = pipe[PIPE_DEPTH-1].br_target;

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Directed bench for simd_alu_pipe at default parameters (8 lanes x 32 bits, depth 2).
// Expected values are hand-computed constants; opcode 2 expectation follows SIMD_ALU_MUL_EN.
module tb_simd_alu_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [2:0]   in_warp_id;
  logic [7:0]   in_mask;
  logic [255:0] in_src1;
  logic [255:0] in_src2;
  logic [15:0]  in_imm;
  logic         in_imm_valid;
  logic         in_reg_write;
  logic [4:0]   in_dst;
  logic         in_beq;
  logic         in_blt;
  logic [1:0]   in_scb_id;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_warp_id;
  logic [7:0]   out_mask;
  logic [4:0]   out_dst;
  logic [1:0]   out_scb_id;
  logic         out_reg_write;
  logic [255:0] out_data;
  logic         out_is_branch;
  logic [7:0]   out_br_taken;
  logic [31:0]  out_br_target;
  logic         err_illegal_op;

  int n_cmp = 0;
  int n_err = 0;

  simd_alu_pipe #(.NUM_LANES(8), .DATA_W(32), .PIPE_DEPTH(2), .WARP_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_warp_id(in_warp_id),
    .in_mask(in_mask), .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
    .in_imm_valid(in_imm_valid), .in_reg_write(in_reg_write), .in_dst(in_dst),
    .in_beq(in_beq), .in_blt(in_blt), .in_scb_id(in_scb_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_warp_id(out_warp_id),
    .out_mask(out_mask), .out_dst(out_dst), .out_scb_id(out_scb_id),
    .out_reg_write(out_reg_write), .out_data(out_data), .out_is_branch(out_is_branch),
    .out_br_taken(out_br_taken), .out_br_target(out_br_target),
    .err_illegal_op(err_illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rep(input logic [31:0] x, input logic [7:0] m);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (m[i]) r[i*32 +: 32] = x;
    return r;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [7:0] m, input logic [15:0] imm, input logic imm_v,
                       input logic beq, input logic blt, input logic rw, input logic [4:0] dst);
    in_valid     = 1'b1;
    in_op        = op;
    in_src1      = rep(s1, 8'hFF);
    in_src2      = rep(s2, 8'hFF);
    in_mask      = m;
    in_imm       = imm;
    in_imm_valid = imm_v;
    in_beq       = beq;
    in_blt       = blt;
    in_reg_write = rw;
    in_dst       = dst;
    in_warp_id   = dst[2:0];
    in_scb_id    = dst[1:0];
  endtask

  // Single isolated transaction: accept, drop in_valid, then the result is at the output.
  task automatic run_one(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [15:0] imm, input logic imm_v, input logic [4:0] dst);
    issue(op, s1, s2, 8'hFF, imm, imm_v, 1'b0, 1'b0, 1'b1, dst);
    step();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    issue(4'd0, 32'd0, 32'd0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    in_valid = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_err", err_illegal_op, 0);
    check("rst_out_data", out_data, 0);
    step(); step();
    rst = 1'b0;

    // Back-to-back stream: ADD, ADD, ADD imm/mask, BLT, illegal
    issue(4'd0, 32'd5, 32'd7, 8'hFF, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1);
    step();
    check("lat_not_1", out_valid, 0);
    issue(4'd0, 32'd10, 32'd20, 8'hFF, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2);
    step();
    check("add1_valid", out_valid, 1);
    check("add1_data", out_data, rep(32'd12, 8'hFF));
    check("add1_dst", out_dst, 5'd1);
    check("add1_rw", out_reg_write, 1);
    issue(4'd0, 32'd3, 32'd100, 8'h0F, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3);
    step();
    check("add2_valid", out_valid, 1);
    check("add2_data", out_data, rep(32'd30, 8'hFF));
    check("add2_warp", out_warp_id, 3'd2);
    issue(4'd1, 32'hFFFF_FFFF, 32'd0, 8'hF0, 16'h0010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
    step();
    check("imm_mask_data", out_data, rep(32'd2, 8'h0F));
    check("imm_mask_mask", out_mask, 8'h0F);
    issue(4'hC, 32'd9, 32'd9, 8'hFF, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
    step();
    in_valid = 1'b0;
    check("blt_is_branch", out_is_branch, 1);
    check("blt_taken", out_br_taken, 8'hF0);
    check("blt_target", out_br_target, 32'h40);
    check("blt_rw", out_reg_write, 0);
    check("blt_data", out_data, 0);
    step();
    check("ill_valid", out_valid, 1);
    check("ill_data", out_data, 0);
    check("ill_rw", out_reg_write, 0);
    check("ill_err", err_illegal_op, 1);
    step();
    check("bubble_after", out_valid, 0);

    // Stall: X at the output, Y behind it, Z waiting at the input
    issue(4'd1, 32'd50, 32'd8, 8'hFF, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6);
    step();
    issue(4'd5, 32'hF0, 32'hFF, 8'hFF, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7);
    step();
    out_ready = 1'b0;
    issue(4'd6, 32'hFFFF_FFF0, 32'd2, 8'hFF, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8);
    #1;
    check("stall_in_ready", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_in_ready_hold", in_ready, 0);
      check("stall_dst_hold", out_dst, 5'd6);
      check("stall_data_hold", out_data, rep(32'd42, 8'hFF));
    end
    out_ready = 1'b1;
    step();
    check("rel_y_dst", out_dst, 5'd7);
    check("rel_y_data", out_data, rep(32'h0F, 8'hFF));
    issue(4'd7, 32'd1, 32'h24, 8'hFF, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9);
    step();
    in_valid = 1'b0;
    check("rel_z_dst", out_dst, 5'd8);
    check("rel_z_sra", out_data, rep(32'hFFFF_FFFC, 8'hFF));
    step();
    check("rel_w_dst", out_dst, 5'd9);
    check("rel_w_sll", out_data, rep(32'd16, 8'hFF));
    step();
    check("rel_drain", out_valid, 0);

    // Remaining opcodes
    run_one(4'd9, 32'hFFFF_FFFD, 32'd2, 16'h0, 1'b0, 5'd10);
    check("min", out_data, rep(32'hFFFF_FFFD, 8'hFF));
    run_one(4'd10, 32'hFFFF_FFFD, 32'd2, 16'h0, 1'b0, 5'd11);
    check("max", out_data, rep(32'd2, 8'hFF));
    run_one(4'd8, 32'hFFFF_FFFD, 32'd0, 16'h0002, 1'b1, 5'd12);
    check("slt_imm", out_data, rep(32'd1, 8'hFF));
    run_one(4'd8, 32'hFFFF_FFFD, 32'hFFFF_FFF0, 16'h0, 1'b0, 5'd13);
    check("slt_false", out_data, 0);
    run_one(4'd3, 32'hC, 32'hA, 16'h0, 1'b0, 5'd14);
    check("and", out_data, rep(32'h8, 8'hFF));
    run_one(4'd4, 32'hC, 32'h1, 16'hFFF0, 1'b1, 5'd15);
    check("or_imm", out_data, rep(32'hFFFF_FFFC, 8'hFF));
    run_one(4'd1, 32'd3, 32'd5, 16'h0001, 1'b1, 5'd16);
    check("sub_wrap_noimm", out_data, rep(32'hFFFF_FFFE, 8'hFF));

    // BEQ and BLT together evaluates as BEQ
    issue(4'd0, 32'd7, 32'd7, 8'hFF, 16'h0003, 1'b0, 1'b1, 1'b1, 1'b1, 5'd17);
    step(); in_valid = 1'b0; step();
    check("beq_pri_taken", out_br_taken, 8'hFF);
    check("beq_pri_target", out_br_target, 32'hC);
    issue(4'd0, 32'd3, 32'd7, 8'hFF, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd18);
    step(); in_valid = 1'b0; step();
    check("beq_pri_ne", out_br_taken, 8'h00);
    check("beq_rw", out_reg_write, 0);

    // Reset in mid-stream
    issue(4'd0, 32'd1, 32'd1, 8'hFF, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd19);
    step();
    issue(4'd0, 32'd2, 32'd2, 8'hFF, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd20);
    step();
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_err", err_illegal_op, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_data", out_data, 0);
    in_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    check("post_rst_discard", out_valid, 0);

    // Opcode 2 depends on the multiplier build option
    run_one(4'd2, 32'h0001_0003, 32'h0002_0005, 16'h0, 1'b0, 5'd21);
`ifdef SIMD_ALU_MUL_EN
    check("mul_data", out_data, rep(32'd15, 8'hFF));
    check("mul_err", err_illegal_op, 0);
`else
    check("mul_off_data", out_data, 0);
    check("mul_off_rw", out_reg_write, 0);
    check("mul_off_err", err_illegal_op, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
